// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a
// blocking whole-line refill over a req/valid burst interface.
module icache_dm #(
  parameter int NLINES         = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_req,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NLINES);
  localparam int TW = 32 - 2 - WB - IB;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state;
  logic [NLINES-1:0]   valid;
  logic [TW-1:0]       tag_mem  [NLINES];
  logic [31:0]         data_mem [NLINES][WORDS_PER_LINE];
  logic [IB-1:0]       fill_idx;
  logic [TW-1:0]       fill_tag;
  logic [WB-1:0]       beat;

  logic [WB-1:0]       cur_word;
  logic [IB-1:0]       cur_idx;
  logic [TW-1:0]       cur_tag;
  logic                hit;
  logic                last_beat;
  logic                start_miss;
  logic                beat_take;
  logic                unused_ok;

  assign cur_word  = cpu_addr[2+WB-1:2];
  assign cur_idx   = cpu_addr[2+WB+IB-1:2+WB];
  assign cur_tag   = cpu_addr[31:2+WB+IB];
  assign unused_ok = ^cpu_addr[1:0];

  assign hit        = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag) && (state == IDLE);
  assign cpu_instr  = hit ? data_mem[cur_idx][cur_word] : 32'h0;
  assign cpu_stall  = cpu_req && !hit;
  assign last_beat  = (beat == WB'(WORDS_PER_LINE - 1));
  // An invalidate in the same cycle as a miss defers the refill by one cycle.
  assign start_miss = (state == IDLE) && cpu_req && !hit && !inv;
  assign beat_take  = (state == REFILL) && mem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      beat     <= '0;
      hit_cnt  <= 16'h0;
      miss_cnt <= 16'h0;
    end else begin
      if (cpu_req && hit)
        hit_cnt <= hit_cnt + 16'd1;
      if (start_miss) begin
        state    <= REFILL;
        beat     <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {cpu_addr[31:2+WB], {(2+WB){1'b0}}};
        miss_cnt <= miss_cnt + 16'd1;
      end
      if (beat_take) begin
        beat     <= beat + 1'b1;
        mem_addr <= mem_addr + 32'd4;
        if (last_beat) begin
          state   <= IDLE;
          mem_req <= 1'b0;
          valid[fill_idx] <= 1'b1;
        end
      end
      // Invalidate overrides the valid bit set by a coincident last beat.
      if (inv)
        valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (start_miss) begin
      fill_idx <= cur_idx;
      fill_tag <= cur_tag;
    end
    if (beat_take) begin
      data_mem[fill_idx][beat] <= mem_rdata;
      if (last_beat)
        tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: refill bursts, hits, conflicts, invalidate,
// spurious mem_valid and reset in the middle of a refill.
module tb_icache_dm;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_valid = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  icache_dm #(.NLINES(16), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
    .cpu_instr(cpu_instr), .cpu_stall(cpu_stall), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory content: a fixed function of the word address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] base, input int gaps, input bit inv_last,
                        input int nbeats);
    logic [31:0] a;
    for (int b = 0; b < nbeats; b++) begin
      a = base + 32'(4 * b);
      for (int g = 0; g < gaps; g++) begin
        mem_valid = 1'b0;
        @(negedge clk);
        chk("gap_addr", mem_addr, a);
        chk("gap_req", mem_req, 1);
        step();
      end
      mem_valid = 1'b1;
      mem_rdata = mw(a);
      inv       = inv_last && (b == WPL - 1);
      @(negedge clk);
      chk("beat_req", mem_req, 1);
      chk("beat_addr", mem_addr, a);
      chk("beat_stall", cpu_stall, cpu_req);
      step();
      mem_valid = 1'b0;
      inv       = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_stall_noreq", cpu_stall, 0);
    step();
    rst_n = 1'b1;

    // Cold miss on line 0
    cpu_req  = 1'b1;
    cpu_addr = 32'h0;
    @(negedge clk);
    chk("cold_stall", cpu_stall, 1);
    chk("cold_instr", cpu_instr, 32'h0);
    chk("cold_req_idle", mem_req, 0);
    step();
    refill(32'h0, 0, 1'b0, 4);
    @(negedge clk);
    chk("fill0_stall", cpu_stall, 0);
    chk("fill0_instr", cpu_instr, 32'hFFFF_0000);
    chk("fill0_miss_cnt", miss_cnt, 1);
    chk("fill0_mem_req", mem_req, 0);
    chk("fill0_hit_cnt", hit_cnt, 0);
    step();

    // Back-to-back hits (word0 cycle above also counted: 1 + 3)
    for (int i = 1; i < 4; i++) begin
      cpu_addr = 32'(4 * i);
      @(negedge clk);
      chk("hit_stall", cpu_stall, 0);
      chk("hit_instr", cpu_instr, mw(32'(4 * i)));
      chk("hit_mem_req", mem_req, 0);
      step();
    end
    @(negedge clk);
    chk("hit_cnt_4", hit_cnt, 4);

    // Conflict 0x100 vs 0x00, with 3 idle cycles between beats
    cpu_addr = 32'h100;
    #1;
    chk("conf_stall", cpu_stall, 1);
    step();
    refill(32'h100, 3, 1'b0, 4);
    @(negedge clk);
    chk("conf_instr", cpu_instr, 32'hFEFF_0100);
    chk("conf_miss_cnt", miss_cnt, 2);
    cpu_addr = 32'h0;
    #1;
    chk("conf_back_stall", cpu_stall, 1);
    step();
    refill(32'h0, 0, 1'b0, 4);
    @(negedge clk);
    chk("conf_back_instr", cpu_instr, 32'hFFFF_0000);
    chk("conf_miss_cnt3", miss_cnt, 3);
    chk("conf_hit_cnt", hit_cnt, 4);

    // Spurious mem_valid while idle
    cpu_req   = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    step();
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("spur_mem_req", mem_req, 0);
    chk("spur_miss_cnt", miss_cnt, 3);
    cpu_req = 1'b1;
    #1;
    chk("spur_stall", cpu_stall, 0);
    chk("spur_instr", cpu_instr, 32'hFFFF_0000);
    cpu_req = 1'b0;
    step();

    // Fill line 1, then invalidate in IDLE
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    step();
    refill(32'h10, 0, 1'b0, 4);
    @(negedge clk);
    chk("l1_instr", cpu_instr, 32'hFFEF_0010);
    cpu_req = 1'b0;
    inv     = 1'b1;
    step();
    inv      = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0;
    @(negedge clk);
    chk("inv_stall_l0", cpu_stall, 1);
    cpu_addr = 32'h10;
    #1;
    chk("inv_stall_l1", cpu_stall, 1);
    chk("inv_instr", cpu_instr, 32'h0);
    cpu_req = 1'b0;
    step();
    @(negedge clk);
    chk("inv_miss_cnt", miss_cnt, 4);
    chk("inv_hit_cnt", hit_cnt, 4);

    // inv coincident with the last refill beat
    cpu_req  = 1'b1;
    cpu_addr = 32'h20;
    step();
    refill(32'h20, 0, 1'b1, 4);
    @(negedge clk);
    chk("invlast_stall", cpu_stall, 1);
    chk("invlast_req_idle", mem_req, 0);
    step();
    refill(32'h20, 0, 1'b0, 4);
    @(negedge clk);
    chk("invlast_miss_cnt", miss_cnt, 6);
    chk("invlast_stall2", cpu_stall, 0);
    chk("invlast_instr", cpu_instr, 32'hFFDF_0020);

    // Reset in the middle of a refill, after two beats
    cpu_addr = 32'h30;
    step();
    refill(32'h30, 0, 1'b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_hit_cnt", hit_cnt, 0);
    chk("midrst_miss_cnt", miss_cnt, 0);
    step();
    rst_n    = 1'b1;
    cpu_addr = 32'h0;
    @(negedge clk);
    chk("postrst_stall", cpu_stall, 1);
    step();
    @(negedge clk);
    chk("postrst_mem_req", mem_req, 1);
    chk("postrst_mem_addr", mem_addr, 0);
    chk("postrst_miss_cnt", miss_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
